// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing the async FIFO write port between NUM_REQ
// producers in the w_clk domain. A grant lasts up to BURST_LEN beats, stalls
// while w_full is high, and always ends with at least one IDLE bubble.
module fifo_wr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MEMORY_WIDTH = 4,
    parameter int BURST_LEN    = 4,
    parameter int ID_WIDTH     = 2
) (
    input  logic                            w_clk,
    input  logic                            wrst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*MEMORY_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            w_full,
    output logic                            w_en,
    output logic [MEMORY_WIDTH-1:0]         wdata,
    output logic [ID_WIDTH-1:0]             grant_id,
    output logic                            busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]          state;
    logic [ID_WIDTH-1:0] last_id;
    logic [3:0]          beat_cnt;
    logic                sel_found;
    logic [ID_WIDTH-1:0] sel_id;
    logic [ID_WIDTH-1:0] cand_id;
    int unsigned         slice_base;

    // Round-robin search: first valid producer at or after last_id+1, wrapping
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        cand_id   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand_id = ID_WIDTH'((32'(last_id) + i) % NUM_REQ);
            if (!sel_found && req_valid[cand_id]) begin
                sel_found = 1'b1;
                sel_id    = cand_id;
            end
        end
    end

    // Write-port outputs: only the owner sees ready, nothing moves while full
    always_comb begin
        req_ready  = '0;
        w_en       = 1'b0;
        wdata      = '0;
        slice_base = 32'(grant_id) * MEMORY_WIDTH;
        if (state == GRANT) begin
            req_ready[grant_id] = !w_full;
            w_en                = req_valid[grant_id] && !w_full;
            if (w_en) begin
                wdata = req_data[slice_base +: MEMORY_WIDTH];
            end
        end
    end

    assign busy = (state == GRANT);

    // Grant FSM: arbitrate in IDLE, count beats / stall / release in GRANT
    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            last_id  <= ID_WIDTH'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_id <= sel_id;
                        last_id  <= sel_id;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!w_full) begin
                        if (req_valid[grant_id]) begin
                            beat_cnt <= beat_cnt + 4'd1;
                            if (beat_cnt + 4'd1 == 4'(BURST_LEN)) begin
                                state <= IDLE;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Self-checking bench: table vectors, hand sequences for stall / release /
// mid-burst reset / FIFO end-to-end, and random traffic against a model.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int MW = 4;
    localparam int BL = 4;
    localparam int IW = 2;

    logic             w_clk = 1'b0;
    logic             wrst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*MW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             w_full;
    logic             w_en;
    logic [MW-1:0]    wdata;
    logic [IW-1:0]    grant_id;
    logic             busy;

    fifo_wr_arbiter #(
        .NUM_REQ     (NR),
        .MEMORY_WIDTH(MW),
        .BURST_LEN   (BL),
        .ID_WIDTH    (IW)
    ) dut (
        .w_clk    (w_clk),
        .wrst_n   (wrst_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .w_full   (w_full),
        .w_en     (w_en),
        .wdata    (wdata),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 w_clk = ~w_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Output bundle layout: {busy, grant_id[1:0], w_en, wdata[3:0], req_ready[3:0]}
    logic [11:0] s_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] mk(input logic b, input logic [1:0] g, input logic we,
                                       input logic [3:0] wd, input logic [3:0] r);
        return {b, g, we, wd, r};
    endfunction

    // Behavioural model: owner (-1 = no grant), rotation pointer, beat count
    int m_owner, m_last, m_beats, m_gid;

    function automatic void model_reset();
        m_owner = -1;
        m_last  = NR - 1;
        m_beats = 0;
        m_gid   = 0;
    endfunction

    function automatic logic [11:0] model_out(input logic [NR-1:0] v, input logic [NR*MW-1:0] d,
                                              input logic f);
        logic          b, we;
        logic [MW-1:0] wd;
        logic [NR-1:0] rdy;
        b   = (m_owner >= 0);
        we  = 1'b0;
        wd  = '0;
        rdy = '0;
        if (b && !f) begin
            rdy[m_gid] = 1'b1;
            we         = v[m_gid];
            if (we) wd = d[m_gid*MW +: MW];
        end
        return {b, 2'(m_gid), we, wd, rdy};
    endfunction

    function automatic void model_step(input logic [NR-1:0] v, input logic f);
        if (m_owner < 0) begin
            for (int k = 1; k <= NR; k++) begin
                int idx;
                idx = (m_last + k) % NR;
                if (v[idx]) begin
                    m_owner = idx;
                    m_gid   = idx;
                    m_last  = idx;
                    m_beats = 0;
                    break;
                end
            end
        end else if (!f) begin
            if (v[m_gid]) begin
                m_beats++;
                if (m_beats == BL) m_owner = -1;
            end else begin
                m_owner = -1;
            end
        end
    endfunction

    // One clock: drive inputs, sample/compare at negedge, advance model at posedge
    task automatic cycle(input logic [NR-1:0] v, input logic [NR*MW-1:0] d, input logic f);
        req_valid = v;
        req_data  = d;
        w_full    = f;
        @(negedge w_clk);
        s_out = {busy, grant_id, w_en, wdata, req_ready};
        check("model", 32'(s_out), 32'(model_out(v, d, f)));
        @(posedge w_clk);
        model_step(v, f);
        #1;
    endtask

    task automatic apply_reset();
        wrst_n    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        w_full    = 1'b0;
        model_reset();
        @(negedge w_clk);
        check("reset values", 32'({busy, grant_id, w_en, wdata, req_ready}), 32'(12'h000));
        @(posedge w_clk);
        #1;
        wrst_n = 1'b1;
    endtask

    typedef struct {
        logic [NR-1:0]    v;
        logic [NR*MW-1:0] d;
        logic             f;
        logic [11:0]      exp;
    } vec_t;

    vec_t vt[15];

    initial begin
        int grants[$];
        int beats[$];
        bit prev_busy;
        int nbeats;
        logic [MW-1:0] fifo_q[$];
        logic [MW-1:0] rd_q[$];
        int p_i[2];
        int viol;
        int exp0, exp1;

        wrst_n    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        w_full    = 1'b0;

        // ---- Table: producer 0 burst of 4, bubble, beat 5, release; then stall/release on p1
        vt[0]  = '{4'b0001, 16'h0001, 1'b0, mk(0, 0, 0, 4'h0, 4'b0000)};
        vt[1]  = '{4'b0001, 16'h0001, 1'b0, mk(1, 0, 1, 4'h1, 4'b0001)};
        vt[2]  = '{4'b0001, 16'h0002, 1'b0, mk(1, 0, 1, 4'h2, 4'b0001)};
        vt[3]  = '{4'b0001, 16'h0003, 1'b0, mk(1, 0, 1, 4'h3, 4'b0001)};
        vt[4]  = '{4'b0001, 16'h0004, 1'b0, mk(1, 0, 1, 4'h4, 4'b0001)};
        vt[5]  = '{4'b0001, 16'h0005, 1'b0, mk(0, 0, 0, 4'h0, 4'b0000)};
        vt[6]  = '{4'b0001, 16'h0005, 1'b0, mk(1, 0, 1, 4'h5, 4'b0001)};
        vt[7]  = '{4'b0000, 16'h0000, 1'b0, mk(1, 0, 0, 4'h0, 4'b0001)};
        vt[8]  = '{4'b0000, 16'h0000, 1'b0, mk(0, 0, 0, 4'h0, 4'b0000)};
        vt[9]  = '{4'b0010, 16'h0070, 1'b0, mk(0, 0, 0, 4'h0, 4'b0000)};
        vt[10] = '{4'b0010, 16'h0070, 1'b1, mk(1, 1, 0, 4'h0, 4'b0000)};
        vt[11] = '{4'b0010, 16'h0070, 1'b0, mk(1, 1, 1, 4'h7, 4'b0010)};
        vt[12] = '{4'b0000, 16'h0000, 1'b1, mk(1, 1, 0, 4'h0, 4'b0000)};
        vt[13] = '{4'b0000, 16'h0000, 1'b0, mk(1, 1, 0, 4'h0, 4'b0010)};
        vt[14] = '{4'b0000, 16'h0000, 1'b0, mk(0, 1, 0, 4'h0, 4'b0000)};

        apply_reset();
        for (int i = 0; i < 15; i++) begin
            cycle(vt[i].v, vt[i].d, vt[i].f);
            check($sformatf("vec[%0d]", i), 32'(s_out), 32'(vt[i].exp));
        end

        // ---- All producers valid: grant order 0,1,2,3,0 with 4 beats each
        apply_reset();
        prev_busy = 1'b0;
        for (int c = 0; c < 26; c++) begin
            cycle(4'b1111, 16'h4321, 1'b0);
            if (s_out[11] && !prev_busy) begin
                grants.push_back(int'(s_out[10:9]));
                beats.push_back(0);
            end
            if (s_out[8] && beats.size() > 0) begin
                beats[beats.size()-1]++;
                check("rr wdata", 32'(s_out[7:4]), 32'(((grants.size() - 1) % NR) + 1));
            end
            prev_busy = s_out[11];
        end
        check("rr grant count", 32'(grants.size()), 32'd5);
        for (int g = 0; g < 5 && g < grants.size(); g++) begin
            check($sformatf("rr grant[%0d]", g), 32'(grants[g]), 32'(g % NR));
            check($sformatf("rr beats[%0d]", g), 32'(beats[g]), 32'(BL));
        end

        // ---- Producer 2 stalled by w_full for 3 cycles mid-burst
        apply_reset();
        nbeats = 0;
        cycle(4'b0100, 16'h0900, 1'b0);
        check("stall idle", 32'(s_out[11]), 32'd0);
        cycle(4'b0100, 16'h0900, 1'b0);
        check("stall gid", 32'(s_out[10:9]), 32'd2);
        if (s_out[8]) nbeats++;
        for (int c = 0; c < 3; c++) begin
            cycle(4'b0100, 16'h0900, 1'b1);
            check("stall w_en", 32'(s_out[8]), 32'd0);
            check("stall ready", 32'(s_out[3:0]), 32'd0);
        end
        for (int c = 0; c < 4; c++) begin
            cycle(4'b0100, 16'h0900, 1'b0);
            if (c == 0) check("stall resume", 32'(s_out[8]), 32'd1);
            if (s_out[8]) nbeats++;
        end
        check("stall burst beats", 32'(nbeats), 32'd4);

        // ---- Producer 1 releases after 2 beats; producer 3 wins next
        apply_reset();
        cycle(4'b1010, 16'h0000, 1'b0);
        cycle(4'b1010, 16'h0000, 1'b0);
        check("release gid", 32'(s_out[10:9]), 32'd1);
        cycle(4'b1010, 16'h0000, 1'b0);
        cycle(4'b1000, 16'h0000, 1'b0);
        check("release no write", 32'(s_out[8]), 32'd0);
        cycle(4'b1010, 16'h0000, 1'b0);
        check("release bubble", 32'(s_out[11]), 32'd0);
        cycle(4'b1010, 16'h0000, 1'b0);
        check("next after release", 32'({s_out[11], s_out[10:9]}), 32'({1'b1, 2'd3}));

        // ---- Asynchronous reset during beat 2 of a grant
        apply_reset();
        cycle(4'b0010, 16'h0050, 1'b0);
        cycle(4'b0010, 16'h0050, 1'b0);
        req_valid = 4'b0010;
        req_data  = 16'h0050;
        w_full    = 1'b0;
        @(negedge w_clk);
        check("beat2 before reset", 32'(w_en), 32'd1);
        #2;
        wrst_n = 1'b0;
        #1;
        check("async reset", 32'({busy, grant_id, w_en, wdata, req_ready}), 32'(12'h000));
        model_reset();
        @(posedge w_clk);
        #1;
        wrst_n = 1'b1;
        cycle(4'b1111, 16'h4321, 1'b0);
        cycle(4'b1111, 16'h4321, 1'b0);
        check("first after reset", 32'({s_out[11], s_out[10:9]}), 32'({1'b1, 2'd0}));

        // ---- End-to-end with a depth-4 FIFO drained every other cycle
        apply_reset();
        p_i[0] = 0;
        p_i[1] = 0;
        viol   = 0;
        for (int c = 0; c < 400; c++) begin
            logic [NR-1:0]    v;
            logic [NR*MW-1:0] d;
            logic             f;
            if (p_i[0] >= 5 && p_i[1] >= 5 && fifo_q.size() == 0) break;
            v = {2'b00, p_i[1] < 5, p_i[0] < 5};
            d = '0;
            d[0 +: MW]  = MW'(p_i[0]);
            d[MW +: MW] = MW'(8 + p_i[1]);
            f = (fifo_q.size() >= 4);
            cycle(v, d, f);
            if (s_out[8] && f) viol++;
            if (s_out[8] && !f) fifo_q.push_back(s_out[7:4]);
            for (int k = 0; k < 2; k++) begin
                if (v[k] && s_out[k]) p_i[k]++;
            end
            if ((c % 2) == 1 && fifo_q.size() > 0) rd_q.push_back(fifo_q.pop_front());
        end
        check("e2e read count", 32'(rd_q.size()), 32'd10);
        check("e2e write while full", 32'(viol), 32'd0);
        exp0 = 0;
        exp1 = 8;
        for (int i = 0; i < rd_q.size(); i++) begin
            if (rd_q[i] < 8) begin
                check("e2e p0 order", 32'(rd_q[i]), 32'(exp0));
                exp0++;
            end else begin
                check("e2e p1 order", 32'(rd_q[i]), 32'(exp1));
                exp1++;
            end
        end
        check("e2e p0 total", 32'(exp0), 32'd5);
        check("e2e p1 total", 32'(exp1), 32'd13);

        // ---- Random traffic against the model
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [NR-1:0]    v;
            logic [NR*MW-1:0] d;
            logic             f;
            v = NR'($urandom);
            d = (NR*MW)'($urandom);
            f = ($urandom_range(0, 3) == 0);
            cycle(v, d, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
